// File: rtl/pll_meas_seq_ctrl.sv
// PLL-lock wait timer and 2^k-sample ADC measurement sequencer driven by CPU start bits.
module pll_meas_seq_ctrl #(
   parameter int unsigned CADC_WIDTH  = 10,
   parameter int unsigned WAIT_W      = 12,
   parameter int unsigned MAX_SLOG2   = 3,
   parameter int unsigned ADC_CLK_DIV = 4,
   parameter int unsigned CONV_CYCLES = 10
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  set_wait_pll_start,
   input  logic [WAIT_W-1:0]     wait_cycles,
   input  logic                  set_meas_adc_start,
   input  logic [2:0]            sample_log2,
   input  logic [CADC_WIDTH-1:0] ADC_DOUT,
   output logic                  wait_pll_is_done,
   output logic                  meas_adc_is_done,
   output logic [CADC_WIDTH-1:0] meas_result,
   output logic                  busy,
   output logic                  RSTN_ADC,
   output logic                  CLK_ADC,
   output logic                  CLRN
);

   localparam int unsigned ACC_W    = CADC_WIDTH + MAX_SLOG2;
   localparam int unsigned SCNT_W   = MAX_SLOG2 + 1;
   localparam int unsigned CONV_LEN = 2 * ADC_CLK_DIV * CONV_CYCLES;
   localparam int unsigned CONV_W   = $clog2(CONV_LEN + 1);
   localparam int unsigned DIV_W    = $clog2(ADC_CLK_DIV + 1);
   localparam int unsigned K_W      = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PLL_WAIT,
      S_MEAS_CLR,
      S_MEAS_CONV,
      S_MEAS_ACC
   } state_e;

   state_e                state_q, state_d;
   logic                  pll_in_q, pll_in_d;
   logic                  meas_in_q, meas_in_d;
   logic                  pll_pend_q, pll_pend_d;
   logic                  meas_pend_q, meas_pend_d;
   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic [K_W-1:0]        k_q, k_d;
   logic [WAIT_W-1:0]     pll_cnt_q, pll_cnt_d;
   logic                  clr_cnt_q, clr_cnt_d;
   logic [CONV_W-1:0]     conv_cnt_q, conv_cnt_d;
   logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [SCNT_W-1:0]     scnt_q, scnt_d;
   logic [CADC_WIDTH-1:0] result_q, result_d;
   logic                  pll_done_q, pll_done_d;
   logic                  meas_done_q, meas_done_d;
   logic                  busy_q, busy_d;
   logic                  rstn_adc_q, rstn_adc_d;
   logic                  clk_adc_q, clk_adc_d;
   logic                  clrn_q, clrn_d;

   logic                  pll_edge_c, meas_edge_c, meas_active_c;
   logic [ACC_W-1:0]      acc_sum_c;
   logic [SCNT_W-1:0]     n_samples_c;

   // Start edge detection and per-sample helpers
   always_comb begin
      pll_edge_c    = set_wait_pll_start & ~pll_in_q;
      meas_edge_c   = set_meas_adc_start & ~meas_in_q;
      meas_active_c = (state_q == S_MEAS_CLR) || (state_q == S_MEAS_CONV) ||
                      (state_q == S_MEAS_ACC);
      acc_sum_c     = acc_q + ACC_W'(ADC_DOUT);
      n_samples_c   = SCNT_W'(1) << k_q;
   end

   // Next-state, request capture, counters and registered-output decode
   always_comb begin
      state_d     = state_q;
      pll_in_d    = set_wait_pll_start;
      meas_in_d   = set_meas_adc_start;
      pll_pend_d  = pll_pend_q;
      meas_pend_d = meas_pend_q;
      wait_d      = wait_q;
      k_d         = k_q;
      pll_cnt_d   = pll_cnt_q;
      clr_cnt_d   = clr_cnt_q;
      conv_cnt_d  = conv_cnt_q;
      div_cnt_d   = div_cnt_q;
      acc_d       = acc_q;
      scnt_d      = scnt_q;
      result_d    = result_q;
      pll_done_d  = pll_done_q;
      meas_done_d = meas_done_q;
      clk_adc_d   = 1'b0;
      rstn_adc_d  = 1'b0;
      clrn_d      = 1'b1;
      busy_d      = 1'b0;

      // Queue a request unless it is a repeat of the operation already running
      if (pll_edge_c && (state_q != S_PLL_WAIT)) begin
         pll_pend_d = 1'b1;
         wait_d     = wait_cycles;
      end
      if (meas_edge_c && !meas_active_c) begin
         meas_pend_d = 1'b1;
         k_d         = (sample_log2 > K_W'(MAX_SLOG2)) ? K_W'(MAX_SLOG2) : sample_log2;
      end

      // Done flags drop when the start is seen low or re-asserted; completion overrides
      if (!set_wait_pll_start || pll_edge_c) pll_done_d = 1'b0;
      if (!set_meas_adc_start || meas_edge_c) meas_done_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // A fresh PLL edge is taken straight away; PLL wins over a pending measurement
            if (pll_pend_q || pll_edge_c) begin
               state_d   = S_PLL_WAIT;
               pll_cnt_d = '0;
            end else if (meas_pend_q) begin
               state_d   = S_MEAS_CLR;
               acc_d     = '0;
               scnt_d    = '0;
               clr_cnt_d = 1'b0;
            end
         end
         S_PLL_WAIT: begin
            if (pll_cnt_q == wait_q) begin
               state_d    = S_IDLE;
               pll_done_d = 1'b1;
               pll_pend_d = 1'b0;
            end else begin
               pll_cnt_d = pll_cnt_q + WAIT_W'(1);
            end
         end
         S_MEAS_CLR: begin
            if (clr_cnt_q) begin
               state_d    = S_MEAS_CONV;
               conv_cnt_d = '0;
               div_cnt_d  = '0;
            end else begin
               clr_cnt_d = 1'b1;
            end
         end
         S_MEAS_CONV: begin
            conv_cnt_d = conv_cnt_q + CONV_W'(1);
            if (conv_cnt_q == CONV_W'(CONV_LEN - 1)) begin
               state_d = S_MEAS_ACC;
            end else if (div_cnt_q == DIV_W'(ADC_CLK_DIV - 1)) begin
               div_cnt_d = '0;
               clk_adc_d = ~clk_adc_q;
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
               clk_adc_d = clk_adc_q;
            end
         end
         S_MEAS_ACC: begin
            acc_d  = acc_sum_c;
            scnt_d = scnt_q + SCNT_W'(1);
            if ((scnt_q + SCNT_W'(1)) == n_samples_c) begin
               state_d     = S_IDLE;
               result_d    = CADC_WIDTH'(acc_sum_c >> k_q);
               meas_done_d = 1'b1;
               meas_pend_d = 1'b0;
            end else begin
               state_d   = S_MEAS_CLR;
               clr_cnt_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      rstn_adc_d = (state_d == S_MEAS_CONV) || (state_d == S_MEAS_ACC);
      clrn_d     = (state_d != S_MEAS_CLR);
      busy_d     = (state_d != S_IDLE) || pll_pend_d || meas_pend_d;
   end

   // State and output registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         pll_in_q    <= 1'b0;
         meas_in_q   <= 1'b0;
         pll_pend_q  <= 1'b0;
         meas_pend_q <= 1'b0;
         wait_q      <= '0;
         k_q         <= '0;
         pll_cnt_q   <= '0;
         clr_cnt_q   <= 1'b0;
         conv_cnt_q  <= '0;
         div_cnt_q   <= '0;
         acc_q       <= '0;
         scnt_q      <= '0;
         result_q    <= '0;
         pll_done_q  <= 1'b0;
         meas_done_q <= 1'b0;
         busy_q      <= 1'b0;
         rstn_adc_q  <= 1'b0;
         clk_adc_q   <= 1'b0;
         clrn_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         pll_in_q    <= pll_in_d;
         meas_in_q   <= meas_in_d;
         pll_pend_q  <= pll_pend_d;
         meas_pend_q <= meas_pend_d;
         wait_q      <= wait_d;
         k_q         <= k_d;
         pll_cnt_q   <= pll_cnt_d;
         clr_cnt_q   <= clr_cnt_d;
         conv_cnt_q  <= conv_cnt_d;
         div_cnt_q   <= div_cnt_d;
         acc_q       <= acc_d;
         scnt_q      <= scnt_d;
         result_q    <= result_d;
         pll_done_q  <= pll_done_d;
         meas_done_q <= meas_done_d;
         busy_q      <= busy_d;
         rstn_adc_q  <= rstn_adc_d;
         clk_adc_q   <= clk_adc_d;
         clrn_q      <= clrn_d;
      end
   end

   assign wait_pll_is_done = pll_done_q;
   assign meas_adc_is_done = meas_done_q;
   assign meas_result      = result_q;
   assign busy             = busy_q;
   assign RSTN_ADC         = rstn_adc_q;
   assign CLK_ADC          = clk_adc_q;
   assign CLRN             = clrn_q;

endmodule

// File: tb/tb_pll_meas_seq_ctrl.sv
// Directed bench for pll_meas_seq_ctrl with an expected-completion scoreboard.
module tb_pll_meas_seq_ctrl;

   localparam int unsigned CW       = 10;
   localparam int unsigned WW       = 12;
   localparam int          DIV      = 4;
   localparam int          CONV     = 10;
   localparam int          MAXK     = 3;
   localparam int          PER_SMPL = 3 + 2 * DIV * CONV;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          set_wait_pll_start = 1'b0;
   logic [WW-1:0] wait_cycles = '0;
   logic          set_meas_adc_start = 1'b0;
   logic [2:0]    sample_log2 = '0;
   logic [CW-1:0] ADC_DOUT = '0;
   logic          wait_pll_is_done, meas_adc_is_done, busy, RSTN_ADC, CLK_ADC, CLRN;
   logic [CW-1:0] meas_result;

   pll_meas_seq_ctrl dut (
      .CLK(CLK), .RST_N(RST_N),
      .set_wait_pll_start(set_wait_pll_start), .wait_cycles(wait_cycles),
      .set_meas_adc_start(set_meas_adc_start), .sample_log2(sample_log2),
      .ADC_DOUT(ADC_DOUT),
      .wait_pll_is_done(wait_pll_is_done), .meas_adc_is_done(meas_adc_is_done),
      .meas_result(meas_result), .busy(busy),
      .RSTN_ADC(RSTN_ADC), .CLK_ADC(CLK_ADC), .CLRN(CLRN)
   );

   always #5 CLK = ~CLK;

   // Count of CLK rising edges; "edge 1" of a run is edge_n+1 at the moment start is driven
   int edge_n = 0;
   always @(posedge CLK) edge_n <= edge_n + 1;

   typedef struct {
      int exp_edge;
      int exp_res;
   } exp_t;

   exp_t pll_q[$];
   exp_t meas_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int adc_data[8];
   int rise_cnt, per_min, per_max;
   bit busy_low;
   int t0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_avg(input int k);
      int keff, n, sum;
      keff = (k > MAXK) ? MAXK : k;
      n    = 1 << keff;
      sum  = 0;
      for (int i = 0; i < n; i++) sum += adc_data[i];
      return sum >> keff;
   endfunction

   function automatic int exp_meas_edge(input int base, input int k);
      int keff;
      keff = (k > MAXK) ? MAXK : k;
      return base + 2 + (1 << keff) * PER_SMPL;
   endfunction

   // Wait (bounded) for a done flag, track CLK_ADC, feed per-sample ADC data, then score it
   task automatic wait_done(input bit is_meas, input int limit, input string tag);
      logic prev_clk;
      int   last_rise;
      bit   seen;
      exp_t e;
      rise_cnt  = 0;
      per_min   = 32'h7fff_ffff;
      per_max   = 0;
      busy_low  = 1'b0;
      prev_clk  = CLK_ADC;
      last_rise = -1;
      seen      = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge CLK);
         if (CLK_ADC && !prev_clk) begin
            rise_cnt++;
            if (last_rise >= 0) begin
               if (edge_n - last_rise < per_min) per_min = edge_n - last_rise;
               if (edge_n - last_rise > per_max) per_max = edge_n - last_rise;
            end
            last_rise = edge_n;
            if (is_meas && (rise_cnt % CONV == 1) && (rise_cnt > 1) && (rise_cnt / CONV < 8))
               ADC_DOUT = CW'(adc_data[rise_cnt / CONV]);
         end
         prev_clk = CLK_ADC;
         if (is_meas ? meas_adc_is_done : wait_pll_is_done) begin
            seen = 1'b1;
            break;
         end
         if (!busy) busy_low = 1'b1;
      end
      chk({tag, "_done_seen"}, 32'(seen), 1);
      chk({tag, "_busy_held"}, 32'(busy_low), 0);
      if (is_meas ? (meas_q.size() == 0) : (pll_q.size() == 0)) begin
         chk({tag, "_sb_empty"}, 0, 1);
      end else begin
         e = is_meas ? meas_q.pop_front() : pll_q.pop_front();
         if (seen) chk({tag, "_edge"}, 32'(edge_n), 32'(e.exp_edge));
         if (is_meas) chk({tag, "_result"}, 32'(meas_result), 32'(e.exp_res));
      end
   endtask

   task automatic start_pll(input int w, input int base);
      wait_cycles        = WW'(w);
      set_wait_pll_start = 1'b1;
      pll_q.push_back('{exp_edge: base + w + 2, exp_res: 0});
   endtask

   task automatic start_meas(input int k, input int base);
      sample_log2        = 3'(k);
      ADC_DOUT           = CW'(adc_data[0]);
      set_meas_adc_start = 1'b1;
      meas_q.push_back('{exp_edge: exp_meas_edge(base, k), exp_res: exp_avg(k)});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge CLK);
      chk("rst_pll_done", 32'(wait_pll_is_done), 0);
      chk("rst_meas_done", 32'(meas_adc_is_done), 0);
      chk("rst_result", 32'(meas_result), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rstn_adc", 32'(RSTN_ADC), 0);
      chk("rst_clk_adc", 32'(CLK_ADC), 0);
      chk("rst_clrn", 32'(CLRN), 1);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);

      // PLL wait W=100 held; sticky done, clears on drop
      t0 = edge_n;
      start_pll(100, t0);
      wait_done(1'b0, 300, "t1");
      repeat (5) @(negedge CLK);
      chk("t1_sticky", 32'(wait_pll_is_done), 1);
      set_wait_pll_start = 1'b0;
      @(negedge CLK);
      chk("t1_clear", 32'(wait_pll_is_done), 0);
      chk("t1_busy_idle", 32'(busy), 0);

      // Minimum latency W=0
      @(negedge CLK);
      t0 = edge_n;
      start_pll(0, t0);
      wait_done(1'b0, 20, "w0");
      set_wait_pll_start = 1'b0;
      @(negedge CLK);

      // Start dropped mid-operation: one-cycle done pulse
      @(negedge CLK);
      t0 = edge_n;
      start_pll(5, t0);
      @(negedge CLK);
      set_wait_pll_start = 1'b0;
      wait_done(1'b0, 30, "pulse");
      @(negedge CLK);
      chk("pulse_drop", 32'(wait_pll_is_done), 0);

      // Single sample, 612
      adc_data = '{612, 612, 612, 612, 612, 612, 612, 612};
      @(negedge CLK);
      t0 = edge_n;
      start_meas(0, t0);
      wait_done(1'b1, 200, "t2");
      chk("t2_rises", 32'(rise_cnt), 10);
      chk("t2_per_min", 32'(per_min), 8);
      chk("t2_per_max", 32'(per_max), 8);
      set_meas_adc_start = 1'b0;
      @(negedge CLK);
      chk("t2_clear", 32'(meas_adc_is_done), 0);

      // Four samples with distinct data, truncated average
      adc_data = '{600, 604, 608, 612, 0, 0, 0, 0};
      @(negedge CLK);
      t0 = edge_n;
      start_meas(2, t0);
      wait_done(1'b1, 400, "t3");
      chk("t3_rises", 32'(rise_cnt), 40);
      set_meas_adc_start = 1'b0;
      repeat (3) @(negedge CLK);
      chk("t3_hold", 32'(meas_result), 32'(exp_avg(2)));

      // Simultaneous starts: PLL first, measurement queued, busy throughout
      adc_data = '{612, 612, 612, 612, 612, 612, 612, 612};
      @(negedge CLK);
      t0 = edge_n;
      start_pll(10, t0);
      start_meas(0, t0);
      meas_q[meas_q.size() - 1].exp_edge = t0 + 12 + PER_SMPL + 1;
      wait_done(1'b0, 50, "t4_pll");
      chk("t4_busy_mid", 32'(busy), 1);
      wait_done(1'b1, 200, "t4_meas");
      chk("t4_busy_end", 32'(busy), 0);
      chk("t4_pll_sticky", 32'(wait_pll_is_done), 1);
      set_wait_pll_start = 1'b0;
      set_meas_adc_start = 1'b0;
      @(negedge CLK);

      // PLL start during a measurement is served afterwards
      @(negedge CLK);
      t0 = edge_n;
      start_meas(0, t0);
      repeat (19) @(negedge CLK);
      wait_cycles        = WW'(3);
      set_wait_pll_start = 1'b1;
      pll_q.push_back('{exp_edge: t0 + 2 + PER_SMPL + 1 + 1 + 3, exp_res: 0});
      wait_done(1'b1, 200, "qp_meas");
      wait_done(1'b0, 50, "qp_pll");
      set_wait_pll_start = 1'b0;
      set_meas_adc_start = 1'b0;
      @(negedge CLK);

      // Reset during conversion, then a clean rerun
      @(negedge CLK);
      t0 = edge_n;
      sample_log2        = 3'd0;
      set_meas_adc_start = 1'b1;
      repeat (49) @(negedge CLK);
      chk("t5_clk_hi", 32'(CLK_ADC), 1);
      RST_N              = 1'b0;
      set_meas_adc_start = 1'b0;
      #1;
      chk("t5_rstn_adc", 32'(RSTN_ADC), 0);
      chk("t5_clk_adc", 32'(CLK_ADC), 0);
      chk("t5_clrn", 32'(CLRN), 1);
      chk("t5_done", 32'(meas_adc_is_done), 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_result", 32'(meas_result), 0);
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (100) @(negedge CLK);
      chk("t5_no_pend_done", 32'(meas_adc_is_done), 0);
      chk("t5_no_pend_busy", 32'(busy), 0);
      t0 = edge_n;
      start_meas(0, t0);
      wait_done(1'b1, 200, "t5_rerun");
      chk("t5_rises", 32'(rise_cnt), 10);
      chk("t5_per", 32'(per_min), 8);
      set_meas_adc_start = 1'b0;
      @(negedge CLK);

      // k=7 clamps to 8 samples of full-scale data
      adc_data = '{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023};
      @(negedge CLK);
      t0 = edge_n;
      start_meas(7, t0);
      wait_done(1'b1, 800, "t6");
      chk("t6_rises", 32'(rise_cnt), 80);
      set_meas_adc_start = 1'b0;
      @(negedge CLK);

      chk("end_pll_sb", 32'(pll_q.size()), 0);
      chk("end_meas_sb", 32'(meas_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
